// File: rtl/gpu_pkg.sv
// Shared encodings and default line geometry for the GPU line scheduler.
package gpu_pkg;

  // One-hot sequencer state encoding.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_FILL  = 4'b0100,
    ST_FLUSH = 4'b1000
  } line_state_t;

  // Default line geometry: 224 words (896 pixels) per line, visible lines 16..239.
  localparam int WORDS_PER_LINE_DEF = 224;
  localparam int VPOS_FIRST_DEF     = 16;
  localparam int VPOS_LAST_DEF      = 239;

  // Completes a word: newest pixel goes to the top lane, earlier lanes below it.
  function automatic logic [31:0] pack_word(input logic [7:0] i_top, input logic [23:0] i_low);
    return {i_top, i_low};
  endfunction

endpackage

// File: rtl/gpu_tgl_sync.sv
// Brings a video-domain toggle into the bus clock domain and turns each
// toggle edge into a single-cycle event.
module gpu_tgl_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tgl,
  output logic o_evt
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser followed by the edge-detect history flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_tgl;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_evt = r_sync ^ r_prev;

endmodule

// File: rtl/gpu_line_sched.sv
// Bus-clock line scheduler: turns video-domain line/frame toggles into
// per-line fills of the scan doubler FIFO, packing 4 pixels per word.
//
// state | meaning
// IDLE  | no line in progress, waiting for a line request
// START | one cycle: bus_eol/src_start pulse, line number latched
// FILL  | accepting pixels, emitting a word every 4th pixel
// FLUSH | one cycle: final word strobe, then pending line or idle
module gpu_line_sched
  import gpu_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int VPOS_FIRST     = VPOS_FIRST_DEF,
  parameter int VPOS_LAST      = VPOS_LAST_DEF
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        line_tgl_vid,
  input  logic        frame_tgl_vid,
  output logic        src_start,
  output logic [8:0]  src_line,
  input  logic [7:0]  pix_data,
  input  logic        pix_vld,
  output logic        pix_rdy,
  output logic        bus_eol,
  output logic [8:0]  bus_vpos,
  output logic [31:0] bus_pix_data,
  output logic        bus_pix_vld,
  output logic        ovr_err,
  input  logic        clr_err
);

  logic        w_line_evt;
  logic        w_frame_evt;

  line_state_t r_state;
  line_state_t w_state_nxt;

  logic [8:0]  r_next_line;
  logic [8:0]  w_nl_base;
  logic        r_pend;
  logic        w_pend_base;
  logic        w_pend_nxt;
  logic        r_ovr_err;
  logic        w_ovr_set;

  logic        w_line_ok;
  logic        w_accept;
  logic        w_word_done;
  logic        w_line_done;
  logic        w_enter_start;

  logic [7:0]  r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_lanes;
  logic [8:0]  r_bus_vpos;
  logic [8:0]  r_src_line;
  logic [31:0] r_bus_pix_data;
  logic        r_bus_pix_vld;

  gpu_tgl_sync u_line_sync (
    .i_clk (bus_clk),
    .i_rst (bus_rst),
    .i_tgl (line_tgl_vid),
    .o_evt (w_line_evt)
  );

  gpu_tgl_sync u_frame_sync (
    .i_clk (bus_clk),
    .i_rst (bus_rst),
    .i_tgl (frame_tgl_vid),
    .o_evt (w_frame_evt)
  );

  // Next-state and request bookkeeping; a frame event is applied before a
  // same-cycle line event, so that line is taken for VPOS_FIRST.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_base = r_pend & ~w_frame_evt;
    w_pend_nxt  = w_pend_base;
    w_ovr_set   = 1'b0;
    w_nl_base   = w_frame_evt ? 9'(VPOS_FIRST) : r_next_line;
    w_line_ok   = w_line_evt && (w_nl_base <= 9'(VPOS_LAST));
    w_accept    = (r_state == ST_FILL) && pix_vld;
    w_word_done = w_accept && (r_byte_cnt == 2'd3);
    w_line_done = w_word_done && (r_word_cnt == 8'(WORDS_PER_LINE - 1));

    case (r_state)
      ST_IDLE: begin
        if (w_line_ok) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_line_ok) begin
          if (w_pend_base) w_ovr_set  = 1'b1;
          else             w_pend_nxt = 1'b1;
        end
        w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_line_ok) begin
          if (w_pend_base) w_ovr_set  = 1'b1;
          else             w_pend_nxt = 1'b1;
        end
        if (w_line_done) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // A request arriving on the flush cycle itself chains straight into
        // START rather than parking in IDLE with pend set.
        if (w_pend_base) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_START;
          if (w_line_ok) w_ovr_set = 1'b1;
        end else if (w_line_ok) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pend_nxt  = 1'b0;
      end
    endcase

    w_enter_start = (w_state_nxt == ST_START);
  end

  // State register.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Line numbering, pending request and sticky overrun (set beats clear).
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_next_line <= 9'(VPOS_FIRST);
      r_pend      <= 1'b0;
      r_ovr_err   <= 1'b0;
    end else begin
      if (w_enter_start)    r_next_line <= w_nl_base + 9'd1;
      else if (w_frame_evt) r_next_line <= 9'(VPOS_FIRST);
      r_pend <= w_pend_nxt;
      if (w_ovr_set)    r_ovr_err <= 1'b1;
      else if (clr_err) r_ovr_err <= 1'b0;
    end
  end

  // Line latch on START entry, pixel packing and word strobe.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_word_cnt     <= 8'd0;
      r_byte_cnt     <= 2'd0;
      r_lanes        <= 24'd0;
      r_bus_vpos     <= 9'd0;
      r_src_line     <= 9'd0;
      r_bus_pix_data <= 32'd0;
      r_bus_pix_vld  <= 1'b0;
    end else begin
      r_bus_pix_vld <= w_word_done;
      if (w_enter_start) begin
        r_bus_vpos <= w_nl_base;
        r_src_line <= w_nl_base;
        r_word_cnt <= 8'd0;
        r_byte_cnt <= 2'd0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_lanes[7:0]   <= pix_data;
          2'd1:    r_lanes[15:8]  <= pix_data;
          2'd2:    r_lanes[23:16] <= pix_data;
          default: begin
            r_bus_pix_data <= pack_word(pix_data, r_lanes);
            r_word_cnt     <= r_word_cnt + 8'd1;
          end
        endcase
      end
    end
  end

  assign src_start    = (r_state == ST_START);
  assign bus_eol      = (r_state == ST_START);
  assign pix_rdy      = (r_state == ST_FILL);
  assign src_line     = r_src_line;
  assign bus_vpos     = r_bus_vpos;
  assign bus_pix_data = r_bus_pix_data;
  assign bus_pix_vld  = r_bus_pix_vld;
  assign ovr_err      = r_ovr_err;

endmodule

// File: tb/tb_gpu_line_sched.sv
// Self-checking bench for gpu_line_sched: a pixel source/word model on the
// full-size instance, plus a short-line instance for the line-number sweep.
module tb_gpu_line_sched;

  localparam int WPL = 224;

  logic        bus_clk = 1'b0;
  logic        bus_rst = 1'b1;
  logic        line_tgl_vid = 1'b0;
  logic        frame_tgl_vid = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_vld = 1'b0;
  logic        src_start, pix_rdy, bus_eol, bus_pix_vld, ovr_err;
  logic [8:0]  src_line, bus_vpos;
  logic [31:0] bus_pix_data;

  logic        line_tgl_s = 1'b0;
  logic        frame_tgl_s = 1'b0;
  logic        src_start_s, pix_rdy_s, bus_eol_s, bus_pix_vld_s, ovr_err_s;
  logic [8:0]  src_line_s, bus_vpos_s;
  logic [31:0] bus_pix_data_s;

  int n_assert = 0;
  int n_fail   = 0;

  gpu_line_sched dut (
    .bus_clk (bus_clk), .bus_rst (bus_rst),
    .line_tgl_vid (line_tgl_vid), .frame_tgl_vid (frame_tgl_vid),
    .src_start (src_start), .src_line (src_line),
    .pix_data (pix_data), .pix_vld (pix_vld), .pix_rdy (pix_rdy),
    .bus_eol (bus_eol), .bus_vpos (bus_vpos),
    .bus_pix_data (bus_pix_data), .bus_pix_vld (bus_pix_vld),
    .ovr_err (ovr_err), .clr_err (clr_err)
  );

  // One word per line keeps the 224-request line-number sweep short.
  gpu_line_sched #(.WORDS_PER_LINE(1)) dut_s (
    .bus_clk (bus_clk), .bus_rst (bus_rst),
    .line_tgl_vid (line_tgl_s), .frame_tgl_vid (frame_tgl_s),
    .src_start (src_start_s), .src_line (src_line_s),
    .pix_data (8'h00), .pix_vld (1'b1), .pix_rdy (pix_rdy_s),
    .bus_eol (bus_eol_s), .bus_vpos (bus_vpos_s),
    .bus_pix_data (bus_pix_data_s), .bus_pix_vld (bus_pix_vld_s),
    .ovr_err (ovr_err_s), .clr_err (1'b0)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  // Source + word model for the full-size instance, evaluated each negedge.
  int          cyc = 0, lp = 0, n_eol = 0, n_words = 0, n_bad = 0;
  int          eol_gap = 0, last_strobe_cyc = 0;
  bit          vld_q = 1'b0, rdy_q = 1'b0, gaps = 1'b0, got_first = 1'b0;
  bit          m_acc, m_exp_vld;
  logic [31:0] m_exp_word;
  logic [8:0]  vpos_first = 9'd0, vpos_last = 9'd0;
  logic [31:0] word_first = 32'd0;

  initial forever begin
    @(negedge bus_clk);
    cyc++;
    if (bus_rst) begin
      lp = 0; vld_q = 1'b0; rdy_q = 1'b0; pix_vld = 1'b0;
    end else begin
      m_acc      = vld_q && rdy_q;
      m_exp_vld  = 1'b0;
      m_exp_word = 32'd0;
      if (m_acc) begin
        lp++;
        if (lp % 4 == 0) begin
          m_exp_vld  = 1'b1;
          m_exp_word = {8'(lp - 1), 8'(lp - 2), 8'(lp - 3), 8'(lp - 4)};
        end
      end
      if (bus_pix_vld !== m_exp_vld) n_bad++;
      if (src_start !== bus_eol) n_bad++;
      if (bus_pix_vld === 1'b1) begin
        n_words++;
        last_strobe_cyc = cyc;
        if (!got_first) begin word_first = bus_pix_data; got_first = 1'b1; end
        if (m_exp_vld && bus_pix_data !== m_exp_word) n_bad++;
      end
      if (bus_eol === 1'b1) begin
        if (bus_pix_vld === 1'b1) n_bad++;
        if (src_line !== bus_vpos) n_bad++;
        if (n_eol == 0) vpos_first = bus_vpos;
        vpos_last = bus_vpos;
        eol_gap = cyc - last_strobe_cyc;
        n_eol++;
        lp = 0;
      end
      pix_data = 8'(lp);
      pix_vld  = gaps ? (cyc % 3 != 0) : 1'b1;
      vld_q    = pix_vld;
      rdy_q    = pix_rdy;
    end
  end

  // Line-number tracker for the short-line instance.
  int         n_eol_s = 0, n_bad_s = 0, exp_vpos_s = 16;
  logic [8:0] last_vpos_s = 9'd0;

  initial forever begin
    @(negedge bus_clk);
    if (!bus_rst && bus_eol_s === 1'b1) begin
      if (bus_vpos_s !== 9'(exp_vpos_s)) n_bad_s++;
      last_vpos_s = bus_vpos_s;
      exp_vpos_s++;
      n_eol_s++;
    end
  end

  task automatic clear_counts();
    n_eol = 0; n_words = 0; n_bad = 0; got_first = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget);
    int i;
    i = 0;
    while (n_words < target && i < budget) begin
      @(negedge bus_clk);
      i++;
    end
    tick(5);
  endtask

  typedef struct {
    int n_tgl;
    bit gaps;
    int exp_lines;
    int exp_vpos0;
    int exp_vposn;
    bit exp_ovr;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   k_lat;
    int   lat_k;

    vecs[0] = '{1, 1'b0, 1, 16, 16, 1'b0};
    vecs[1] = '{1, 1'b1, 1, 16, 16, 1'b0};
    vecs[2] = '{2, 1'b0, 2, 16, 17, 1'b0};
    vecs[3] = '{3, 1'b0, 2, 16, 17, 1'b1};
    lat_k = 3;

    tick(2);
    check("rst bus_eol",      32'(bus_eol), 32'd0);
    check("rst src_start",    32'(src_start), 32'd0);
    check("rst pix_rdy",      32'(pix_rdy), 32'd0);
    check("rst bus_pix_vld",  32'(bus_pix_vld), 32'd0);
    check("rst bus_vpos",     32'(bus_vpos), 32'd0);
    check("rst src_line",     32'(src_line), 32'd0);
    check("rst bus_pix_data", bus_pix_data, 32'd0);
    check("rst ovr_err",      32'(ovr_err), 32'd0);
    bus_rst = 1'b0;
    tick(4);

    for (int v = 0; v < 4; v++) begin
      gaps = vecs[v].gaps;
      clear_counts();
      frame_tgl_vid = ~frame_tgl_vid;
      tick(8);
      line_tgl_vid = ~line_tgl_vid;
      k_lat = 0;
      while (k_lat < 12 && bus_eol !== 1'b1) begin
        @(negedge bus_clk);
        k_lat++;
      end
      if (v == 0) lat_k = k_lat;
      check($sformatf("v%0d toggle->eol latency in 3..4", v), 32'(k_lat >= 3 && k_lat <= 4), 32'd1);
      for (int t = 1; t < vecs[v].n_tgl; t++) begin
        tick(200);
        line_tgl_vid = ~line_tgl_vid;
      end
      wait_words(vecs[v].exp_lines * WPL, 3000 * vecs[v].exp_lines);
      check($sformatf("v%0d eol count", v),   32'(n_eol), 32'(vecs[v].exp_lines));
      check($sformatf("v%0d word count", v),  32'(n_words), 32'(vecs[v].exp_lines * WPL));
      check($sformatf("v%0d first vpos", v),  32'(vpos_first), 32'(vecs[v].exp_vpos0));
      check($sformatf("v%0d last vpos", v),   32'(vpos_last), 32'(vecs[v].exp_vposn));
      check($sformatf("v%0d first word", v),  word_first, 32'h03020100);
      check($sformatf("v%0d model errors", v), 32'(n_bad), 32'd0);
      check($sformatf("v%0d ovr_err", v),     32'(ovr_err), 32'(vecs[v].exp_ovr));
      check($sformatf("v%0d idle pix_rdy", v), 32'(pix_rdy), 32'd0);
      if (vecs[v].exp_lines == 2)
        check($sformatf("v%0d flush->eol gap", v), 32'(eol_gap), 32'd1);
    end
    gaps = 1'b0;

    // clr_err alone clears the sticky flag.
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err clears ovr_err", 32'(ovr_err), 32'd0);

    // A new overrun in the same cycle as clr_err keeps the flag set.
    clear_counts();
    frame_tgl_vid = ~frame_tgl_vid;
    tick(8);
    line_tgl_vid = ~line_tgl_vid;
    tick(100);
    check("fill pix_rdy", 32'(pix_rdy), 32'd1);
    line_tgl_vid = ~line_tgl_vid;
    tick(100);
    check("pend without ovr", 32'(ovr_err), 32'd0);
    line_tgl_vid = ~line_tgl_vid;
    tick(lat_k - 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("set beats clear", 32'(ovr_err), 32'd1);
    wait_words(2 * WPL, 6000);
    check("overrun eol count", 32'(n_eol), 32'd2);
    check("overrun model errors", 32'(n_bad), 32'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;

    // Reset in the middle of a line.
    clear_counts();
    frame_tgl_vid = ~frame_tgl_vid;
    tick(8);
    line_tgl_vid = ~line_tgl_vid;
    begin
      int i;
      i = 0;
      while (n_words < 100 && i < 1500) begin
        @(negedge bus_clk);
        i++;
      end
    end
    check("reached word 100", 32'(n_words >= 100), 32'd1);
    bus_rst = 1'b1;
    line_tgl_vid = 1'b0; frame_tgl_vid = 1'b0;
    line_tgl_s = 1'b0;   frame_tgl_s = 1'b0;
    #1;
    check("mid rst pix_rdy",      32'(pix_rdy), 32'd0);
    check("mid rst bus_eol",      32'(bus_eol), 32'd0);
    check("mid rst bus_pix_vld",  32'(bus_pix_vld), 32'd0);
    check("mid rst bus_vpos",     32'(bus_vpos), 32'd0);
    check("mid rst src_line",     32'(src_line), 32'd0);
    check("mid rst bus_pix_data", bus_pix_data, 32'd0);
    tick(3);
    bus_rst = 1'b0;
    tick(3);
    clear_counts();
    frame_tgl_vid = ~frame_tgl_vid;
    tick(8);
    line_tgl_vid = ~line_tgl_vid;
    wait_words(WPL, 3000);
    check("post rst eol count",  32'(n_eol), 32'd1);
    check("post rst word count", 32'(n_words), 32'(WPL));
    check("post rst vpos",       32'(vpos_first), 32'd16);
    check("post rst first word", word_first, 32'h03020100);
    check("post rst model errs", 32'(n_bad), 32'd0);

    // 225 requests after a frame start: 16..239 written, the last ignored.
    exp_vpos_s = 16; n_eol_s = 0; n_bad_s = 0;
    frame_tgl_s = ~frame_tgl_s;
    tick(8);
    for (int i = 0; i < 225; i++) begin
      line_tgl_s = ~line_tgl_s;
      tick(14);
    end
    check("sweep line count",  32'(n_eol_s), 32'd224);
    check("sweep last vpos",   32'(last_vpos_s), 32'd239);
    check("sweep sequence",    32'(n_bad_s), 32'd0);
    check("sweep no overrun",  32'(ovr_err_s), 32'd0);
    exp_vpos_s = 16;
    frame_tgl_s = ~frame_tgl_s;
    tick(8);
    line_tgl_s = ~line_tgl_s;
    tick(14);
    check("restart line count", 32'(n_eol_s), 32'd225);
    check("restart vpos",       32'(last_vpos_s), 32'd16);
    check("restart sequence",   32'(n_bad_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpu_line_sched.md
Name: gpu_line_sched

Overview:
Bus-clock (72 MHz) sequencer that feeds the scan doubler's 2-line FIFO write port.
- Synchronises the video-domain line and frame requests into bus_clk.
- Starts the pixel source for each line, packs its 8-bit pixels into 32-bit words, and drives bus_eol, bus_vpos, bus_pix_data and bus_pix_vld.
- Holds at most one pending line request and flags overruns.

Parameters:
WORDS_PER_LINE, 224, 32-bit words written per line (4 pixels per word)
VPOS_FIRST, 16, first visible line number issued after a frame start
VPOS_LAST, 239, last visible line; requests beyond it are ignored

Ports:
bus_clk  in  1  bus clock, 72 MHz
bus_rst  in  1  reset, asynchronous, active-high
line_tgl_vid  in  1  vid_clk-domain toggle, one edge per line request
frame_tgl_vid  in  1  vid_clk-domain toggle, one edge per frame start
src_start  out  1  one-cycle pulse: pixel source begins rendering line src_line
src_line  out  9  line number being rendered
pix_data  in  8  pixel (palette index) from source
pix_vld  in  1  pixel valid
pix_rdy  out  1  scheduler accepts pixel
bus_eol  out  1  one-cycle pulse, rewinds FIFO write address
bus_vpos  out  9  line number; bit 0 selects FIFO half
bus_pix_data  out  32  packed word, pixel n in bits [8n+7:8n]
bus_pix_vld  out  1  word write strobe
ovr_err  out  1  sticky overrun flag
clr_err  in  1  synchronous clear of ovr_err

Behaviour:
- CDC: each toggle passes through a 2-FF synchroniser plus an edge-detect flop. A detected edge is a one-cycle event, 3 to 4 bus_clk after the toggle.
- Frame event:
  - sets next_line = VPOS_FIRST and drops any pending request;
  - does not abort a line already in FILL.
  - If a frame event and a line event arrive in the same cycle, the frame event is applied first and the line request is then taken for VPOS_FIRST.
- Line event:
  - IDLE: go to START.
  - Any other state: set pend=1. If pend was already 1, set ovr_err=1 and drop the event.
  - Any state, next_line > VPOS_LAST: the event is ignored entirely; no pend, no error.
- FSM states IDLE, START, FILL, FLUSH:
  - START (1 cycle): bus_eol=1, bus_vpos<=next_line, src_line<=next_line, src_start=1, next_line<=next_line+1, word_cnt<=0, byte_cnt<=0. Next state FILL.
  - FILL: pix_rdy=1. On pix_vld&pix_rdy, write pix_data into byte lane byte_cnt and increment byte_cnt (2-bit, wraps). When byte_cnt==3 and a pixel is accepted, the next cycle has bus_pix_vld=1 with the completed word, and word_cnt increments.
  - FILL exit: the 4th pixel of word WORDS_PER_LINE-1 is accepted. Drop pix_rdy on that same cycle and go to FLUSH.
  - FLUSH (1 cycle, final word strobe): if pend, clear pend and go to START; otherwise go to IDLE.
- Pixel acceptance rule: pix_rdy=0 outside FILL; pixels offered then are not consumed.
- Throughput: one pixel per cycle when pix_vld is held high.
- Latency:
  - line edge detected to bus_eol: 1 cycle;
  - 4th pixel accepted to bus_pix_vld: 1 cycle.
- bus_pix_vld is never asserted in the same cycle as bus_eol.
- Reset values: state IDLE, all pulses 0, pix_rdy 0, bus_vpos 0, src_line 0, bus_pix_data 0, next_line VPOS_FIRST, pend 0, ovr_err 0, synchroniser flops 0.
- Reset mid-line abandons the partial word with no strobe. The first toggle edge after reset is detected normally.
- ovr_err: clr_err clears it. If clr_err and a new overrun occur in the same cycle, set wins.
- Counter widths: word_cnt is 8 bits; next_line is 9 bits with no wrap, because the VPOS_LAST guard stops it.

Decomposition:
- gpu_pkg: FSM state encoding (one-hot, 4 bits) and the default line constants (224, 16, 239).
- Sub-module gpu_tgl_sync (2-FF synchroniser + edge detect), instantiated twice.

Test Plan:
- Frame toggle, then line toggle, source supplying pixels 0x00..0xFF repeating at 1/cycle:
  - bus_eol once with bus_vpos=16;
  - 224 bus_pix_vld strobes, first word 0x03020100;
  - then IDLE.
- Source inserts pix_vld gaps every 3rd cycle: same 224 words and data as the unstalled run; no strobe during a gap that leaves a word incomplete.
- Line toggle during FILL: pend=1; second line starts (bus_vpos=17) directly after FLUSH with no IDLE cycle.
- Three line toggles within one line: ovr_err=1; exactly two lines written.
  - clr_err clears ovr_err.
  - clr_err pulsed in the same cycle as a new overrun leaves ovr_err=1.
- 224 line requests after a frame start: lines 16..239 written; 225th request is ignored, ovr_err stays 0.
  - Next frame toggle restarts at 16.
- bus_rst asserted at word 100 of a line:
  - all outputs return to reset values immediately;
  - the next frame+line pair writes a full line at bus_vpos=16.
